// File: rtl/haar_filter_mc.sv
// Multichannel time-multiplexed Haar analysis cascade. Each stage keeps one held
// sample and one phase bit per channel. Each stage has one pipeline register, and every output is saturated.
module haar_filter_mc #(
   parameter int CHANNELS       = 4,
   parameter int STAGES         = 8,
   parameter int IN_WIDTH       = 16,
   parameter int INTERNAL_WIDTH = 18,
   parameter int OUT_WIDTH      = 16,
   parameter int ROUND          = 0,
   parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                             clk,
   input  logic                             rstN,
   input  logic                             en,
   input  logic [CH_W-1:0]                  chIn,
   input  logic [IN_WIDTH-1:0]              dataIn,
   output logic [STAGES:0]                  outStrobes,
   output logic [CH_W*(STAGES+1)-1:0]       outChannel,
   output logic [OUT_WIDTH*(STAGES+1)-1:0]  dataOut
);
   localparam int            IW     = INTERNAL_WIDTH;
   localparam logic [CH_W:0] NUM_CH = (CH_W+1)'(CHANNELS);
   localparam logic [IW:0]   RND    = (IW+1)'(ROUND);

   // Clamp a working-width value into the signed output range.
   function automatic logic [OUT_WIDTH-1:0] saturate(input logic [IW-1:0] x);
      logic [IW-OUT_WIDTH:0] top;
      top = x[IW-1:OUT_WIDTH-1];
      if (&top || ~|top) return x[OUT_WIDTH-1:0];
      else if (x[IW-1])  return {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else               return {1'b0, {(OUT_WIDTH-1){1'b1}}};
   endfunction

   logic            in_v;
   logic [CH_W-1:0] in_ch;
   logic [IW-1:0]   in_d;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         in_v  <= 1'b0;
         in_ch <= '0;
         in_d  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values,
         // so the stage chain below behaves as a true one-register-per-stage pipeline.
         in_v  <= en && ({1'b0, chIn} < NUM_CH);
         in_ch <= chIn;
         in_d  <= IW'($signed(dataIn));
      end
   end

   // Approximation hand-off from each stage to the next.
   logic [STAGES-1:0]           fwd_v;
   logic [STAGES-1:0][CH_W-1:0] fwd_ch;
   logic [STAGES-1:0][IW-1:0]   fwd_d;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic                v;
      logic [CH_W-1:0]     ch;
      logic [IW-1:0]       a;
      logic [IW-1:0]       b;
      logic [IW:0]         sum;
      logic [IW:0]         dif;
      logic [IW-1:0]       held [CHANNELS];
      logic [CHANNELS-1:0] phase;
      logic                out_v;
      logic [CH_W-1:0]     out_ch;
      logic [IW-1:0]       det_q;
      logic [IW-1:0]       apx_q;

      if (k == 0) begin : g_src
         assign v  = in_v;
         assign ch = in_ch;
         assign b  = in_d;
      end else begin : g_src
         assign v  = fwd_v[k-1];
         assign ch = fwd_ch[k-1];
         assign b  = fwd_d[k-1];
      end

      assign a   = held[ch];
      assign sum = {a[IW-1], a} + {b[IW-1], b} + RND;
      assign dif = {a[IW-1], a} - {b[IW-1], b} + RND;

      always_ff @(posedge clk or negedge rstN) begin
         if (!rstN) begin
            // NOTE: the held-sample array is reset together with the phase bits, so a
            // reset leaves no trace of a half-collected pair in any channel.
            for (int c = 0; c < CHANNELS; c++) held[c] <= '0;
            phase  <= '0;
            out_v  <= 1'b0;
            out_ch <= '0;
            det_q  <= '0;
            apx_q  <= '0;
         end else begin
            out_v <= 1'b0;
            if (v) begin
               if (!phase[ch]) begin
                  held[ch]  <= b;
                  phase[ch] <= 1'b1;
               end else begin
                  phase[ch] <= 1'b0;
                  out_v     <= 1'b1;
                  out_ch    <= ch;
                  det_q     <= dif[IW:1];
                  apx_q     <= sum[IW:1];
               end
            end
         end
      end

      assign fwd_v[k]  = out_v;
      assign fwd_ch[k] = out_ch;
      assign fwd_d[k]  = apx_q;

      assign outStrobes[k]                     = out_v;
      assign outChannel[k*CH_W +: CH_W]        = out_ch;
      assign dataOut[k*OUT_WIDTH +: OUT_WIDTH] = saturate(det_q);
   end

   assign outStrobes[STAGES]                     = fwd_v[STAGES-1];
   assign outChannel[STAGES*CH_W +: CH_W]        = fwd_ch[STAGES-1];
   assign dataOut[STAGES*OUT_WIDTH +: OUT_WIDTH] = saturate(fwd_d[STAGES-1]);

endmodule

// File: tb/tb_haar_filter_mc.sv
// Directed bench for haar_filter_mc: the default build plus rounding, narrow-output
// and three-channel variants, all driven from one shared stimulus stream.
module tb_haar_filter_mc;
   localparam int S = 3;

   logic        clk = 1'b0;
   logic        rstN;
   logic        en;
   logic [1:0]  ch;
   logic [15:0] din;

   always #5 clk = ~clk;

   logic [S:0]          st0, str, sts, stc;
   logic [S:0]          ch0o, chro, chso;
   logic [2*(S+1)-1:0]  chco;
   logic [16*(S+1)-1:0] do0, dor, doc;
   logic [8*(S+1)-1:0]  dos;

   int vectors     = 0;
   int miscompares = 0;

   haar_filter_mc #(.CHANNELS(2), .STAGES(S), .IN_WIDTH(16), .INTERNAL_WIDTH(18),
                    .OUT_WIDTH(16), .ROUND(0)) dut (
      .clk(clk), .rstN(rstN), .en(en), .chIn(ch[0]), .dataIn(din),
      .outStrobes(st0), .outChannel(ch0o), .dataOut(do0));

   haar_filter_mc #(.CHANNELS(2), .STAGES(S), .IN_WIDTH(16), .INTERNAL_WIDTH(18),
                    .OUT_WIDTH(16), .ROUND(1)) dut_rnd (
      .clk(clk), .rstN(rstN), .en(en), .chIn(ch[0]), .dataIn(din),
      .outStrobes(str), .outChannel(chro), .dataOut(dor));

   haar_filter_mc #(.CHANNELS(2), .STAGES(S), .IN_WIDTH(16), .INTERNAL_WIDTH(18),
                    .OUT_WIDTH(8), .ROUND(0)) dut_sat (
      .clk(clk), .rstN(rstN), .en(en), .chIn(ch[0]), .dataIn(din),
      .outStrobes(sts), .outChannel(chso), .dataOut(dos));

   haar_filter_mc #(.CHANNELS(3), .STAGES(S), .IN_WIDTH(16), .INTERNAL_WIDTH(18),
                    .OUT_WIDTH(16), .ROUND(0)) dut_ch3 (
      .clk(clk), .rstN(rstN), .en(en), .chIn(ch), .dataIn(din),
      .outStrobes(stc), .outChannel(chco), .dataOut(doc));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int c, input int d);
      en  = 1'b1;
      ch  = c[1:0];
      din = d[15:0];
      tick();
      en  = 1'b0;
   endtask

   task automatic apply_reset();
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      send(0, 10);
      send(0, 4);
      tick();
      vectors++;
      if (st0 !== 4'b0001 || do0[15:0] !== 16'd3) begin
         miscompares++;
         $display("FAIL reset_warmup: strobes=%b slot0=%0d, want 0001 and 3", st0, $signed(do0[15:0]));
      end
      rstN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(i % 2, 77 + i);
         vectors++;
         if ({st0, ch0o, do0} !== '0 || {stc, chco, doc} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: strobes=%b ch=%b data=%h, want all zero", st0, ch0o, do0);
         end
      end
      rstN = 1'b1;
      send(0, 10);
      apply_reset();
      send(0, 4);
      send(0, 6);
      tick();
      vectors++;
      if (st0 !== 4'b0001 || do0[15:0] !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL reset_midop: strobes=%b slot0=%0d, want 0001 and -1", st0, $signed(do0[15:0]));
      end
   endtask

   task automatic test_cascade();
      apply_reset();
      send(0, 10);
      send(0, 4);
      tick();
      vectors++;
      if (st0 !== 4'b0001 || do0[15:0] !== 16'd3 || ch0o[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL cascade_pair1: strobes=%b slot0=%0d, want 0001 and 3", st0, $signed(do0[15:0]));
      end
      tick();
      vectors++;
      if (st0 !== 4'b0000 || do0[15:0] !== 16'd3) begin
         miscompares++;
         $display("FAIL cascade_hold: strobes=%b slot0=%0d, want 0000 and 3", st0, $signed(do0[15:0]));
      end
      send(0, 6);
      send(0, 2);
      tick();
      vectors++;
      if (st0 !== 4'b0001 || do0[15:0] !== 16'd2) begin
         miscompares++;
         $display("FAIL cascade_pair2: strobes=%b slot0=%0d, want 0001 and 2", st0, $signed(do0[15:0]));
      end
      tick();
      vectors++;
      if (st0 !== 4'b0010 || do0[31:16] !== 16'd1 || ch0o[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL cascade_stage1: strobes=%b slot1=%0d, want 0010 and 1", st0, $signed(do0[31:16]));
      end

      apply_reset();
      for (int i = 0; i < 8; i++) send(0, 100);
      tick();
      vectors++;
      if (st0 !== 4'b0001 || do0[15:0] !== 16'd0) begin
         miscompares++;
         $display("FAIL const_t1: strobes=%b slot0=%0d, want 0001 and 0", st0, $signed(do0[15:0]));
      end
      tick();
      vectors++;
      if (st0 !== 4'b0010 || do0[31:16] !== 16'd0) begin
         miscompares++;
         $display("FAIL const_t2: strobes=%b slot1=%0d, want 0010 and 0", st0, $signed(do0[31:16]));
      end
      tick();
      vectors++;
      if (st0 !== 4'b1100 || do0[47:32] !== 16'd0 || do0[63:48] !== 16'd100) begin
         miscompares++;
         $display("FAIL const_t3: strobes=%b slot2=%0d slot3=%0d, want 1100, 0, 100",
                  st0, $signed(do0[47:32]), $signed(do0[63:48]));
      end
   endtask

   // Alternating ch0=100 / ch1=-100 every cycle; expected strobes come from the
   // per-channel pair count of the sample that entered k+1 cycles earlier.
   task automatic test_interleave();
      logic [S:0]  exp_st;
      logic [15:0] ev;
      int          s;
      apply_reset();
      for (int i = 0; i < 36; i++) begin
         if (i < 32) begin
            en  = 1'b1;
            ch  = 2'(i % 2);
            din = (i % 2 == 1) ? 16'hFF9C : 16'd100;
         end else begin
            en = 1'b0;
         end
         tick();
         exp_st = '0;
         for (int k = 0; k < S; k++) begin
            s = i - k - 1;
            if (s >= 0 && s < 32 && ((s / 2) % (1 << (k + 1))) == (1 << (k + 1)) - 1)
               exp_st[k] = 1'b1;
         end
         exp_st[S] = exp_st[S-1];
         vectors++;
         if (st0 !== exp_st) begin
            miscompares++;
            $display("FAIL interleave_strobe i=%0d: strobes=%b, want %b", i, st0, exp_st);
         end
         for (int k = 0; k <= S; k++) begin
            if (exp_st[k]) begin
               s  = i - ((k == S) ? S : k + 1);
               ev = (k != S) ? 16'd0 : ((s % 2 == 1) ? 16'hFF9C : 16'd100);
               vectors++;
               if (do0[k*16 +: 16] !== ev || ch0o[k] !== 1'(s % 2)) begin
                  miscompares++;
                  $display("FAIL interleave_slot%0d i=%0d: data=%0d ch=%0d, want %0d ch %0d",
                           k, i, $signed(do0[k*16 +: 16]), ch0o[k], $signed(ev), s % 2);
               end
            end
         end
      end
   endtask

   task automatic test_rounding();
      apply_reset();
      send(0, -3);
      send(0, 0);
      tick();
      vectors++;
      if (st0[0] !== 1'b1 || do0[15:0] !== 16'hFFFE) begin
         miscompares++;
         $display("FAIL round_floor: strobe=%b slot0=%0d, want 1 and -2", st0[0], $signed(do0[15:0]));
      end
      vectors++;
      if (str[0] !== 1'b1 || dor[15:0] !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL round_half_up: strobe=%b slot0=%0d, want 1 and -1", str[0], $signed(dor[15:0]));
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      send(0, 32767);
      send(0, -32768);
      tick();
      vectors++;
      if (sts[0] !== 1'b1 || dos[7:0] !== 8'h7F || do0[15:0] !== 16'h7FFF) begin
         miscompares++;
         $display("FAIL sat_pos: slot0_8b=%0d slot0_16b=%0d, want 127 and 32767",
                  $signed(dos[7:0]), $signed(do0[15:0]));
      end
      send(0, -32768);
      send(0, 32767);
      tick();
      vectors++;
      if (sts[0] !== 1'b1 || dos[7:0] !== 8'h80 || do0[15:0] !== 16'h8000) begin
         miscompares++;
         $display("FAIL sat_neg: slot0_8b=%0d slot0_16b=%0d, want -128 and -32768",
                  $signed(dos[7:0]), $signed(do0[15:0]));
      end
   endtask

   task automatic test_invalid_channel();
      apply_reset();
      send(0, 8);
      send(3, 500);
      tick();
      vectors++;
      if (stc !== 4'b0000) begin
         miscompares++;
         $display("FAIL invalid_strobe: strobes=%b, want 0000", stc);
      end
      send(0, 2);
      tick();
      vectors++;
      if (stc !== 4'b0001 || doc[15:0] !== 16'd3 || chco[1:0] !== 2'd0) begin
         miscompares++;
         $display("FAIL invalid_state: strobes=%b slot0=%0d ch=%0d, want 0001, 3, 0",
                  stc, $signed(doc[15:0]), chco[1:0]);
      end
   endtask

   initial begin
      rstN = 1'b1;
      en   = 1'b0;
      ch   = 2'd0;
      din  = 16'd0;
      #2 rstN = 1'b0;
      tick();
      tick();
      rstN = 1'b1;
      test_reset();
      test_cascade();
      test_interleave();
      test_rounding();
      test_saturation();
      test_invalid_channel();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
